// File: rtl/simon_decrypt_iterative_if.sv
`default_nettype none
// ============================================================================
// Module      : simon_decrypt_iterative_if
// Description : Job/result handshake bundle for the SIMON32/64 decryptor.
//               The slave modport is the core side and the master modport is
//               the requester side.
// Revision    : 1.0 - initial release
// ============================================================================
interface simon_decrypt_iterative_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ciphertext;
    logic [63:0] key;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] plaintext;
    logic        busy;

    modport master (
        output in_valid, ciphertext, key, out_ready,
        input  in_ready, out_valid, plaintext, busy
    );

    modport slave (
        input  in_valid, ciphertext, key, out_ready,
        output in_ready, out_valid, plaintext, busy
    );
endinterface
`default_nettype wire

// File: rtl/simon_decrypt_iterative.sv
`default_nettype none
// ============================================================================
// Module      : simon_decrypt_iterative
// Description : Iterative SIMON32/64 decryption core. Expands the key schedule
//               forward to k31 in a 4-word window, then runs 32 inverse rounds
//               while stepping the window backward to regenerate k31..k0.
// Revision    : 1.0 - initial release
// ============================================================================
module simon_decrypt_iterative #(
    parameter int NUM_ROUNDS = 32,
    parameter int KEY_WORDS  = 4
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    simon_decrypt_iterative_if.slave  bus
);

    localparam logic [1:0]  c_idle = 2'd0;
    localparam logic [1:0]  c_kexp = 2'd1;
    localparam logic [1:0]  c_dec  = 2'd2;
    localparam logic [1:0]  c_done = 2'd3;

    localparam logic [15:0] c_const     = 16'hFFFC;
    localparam logic [61:0] c_z0        = 62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [4:0]  c_kexp_last = 5'(NUM_ROUNDS - KEY_WORDS - 1);
    localparam logic [4:0]  c_dec_last  = 5'(NUM_ROUNDS - 1);

    logic [1:0]  r_state;
    logic [4:0]  r_rcnt;
    logic [15:0] r_x;
    logic [15:0] r_y;
    logic [15:0] r_w0;
    logic [15:0] r_w1;
    logic [15:0] r_w2;
    logic [15:0] r_w3;

    logic [5:0]  w_zidx;
    logic        w_z;
    logic [15:0] w_t;
    logic [15:0] w_u;
    logic [15:0] w_kfwd;
    logic [15:0] w_kback;
    logic [15:0] w_y_new;

    function automatic logic [15:0] ror1(input logic [15:0] v);
        return {v[0], v[15:1]};
    endfunction

    function automatic logic [15:0] ror3(input logic [15:0] v);
        return {v[2:0], v[15:3]};
    endfunction

    // SIMON round function: (ROL1 & ROL8) ^ ROL2
    function automatic logic [15:0] simon_f(input logic [15:0] v);
        return ({v[14:0], v[15]} & {v[7:0], v[15:8]}) ^ {v[13:0], v[15:14]};
    endfunction

    // Constant-sequence bit and forward/backward key-schedule steps
    always_comb begin
        w_zidx = 6'd0;
        if (r_state == c_kexp) begin
            w_zidx = {1'b0, r_rcnt};
        end else if (r_rcnt <= c_kexp_last) begin
            // backward walk reads z in reverse; clamped past k0 where it is unused
            w_zidx = 6'd27 - {1'b0, r_rcnt};
        end
        w_z     = c_z0[6'd61 - w_zidx];
        w_t     = ror3(r_w3) ^ r_w1;
        w_kfwd  = ~r_w0 ^ w_t ^ ror1(w_t) ^ {15'd0, w_z} ^ 16'h0003;
        w_u     = ror3(r_w2) ^ r_w0;
        w_kback = r_w3 ^ c_const ^ {15'd0, w_z} ^ w_u ^ ror1(w_u);
        w_y_new = r_x ^ simon_f(r_y) ^ r_w3;
    end

    assign bus.in_ready  = (r_state == c_idle);
    assign bus.out_valid = (r_state == c_done);
    assign bus.busy      = (r_state == c_kexp) || (r_state == c_dec);
    assign bus.plaintext = {r_x, r_y};

    // Control FSM, data block and key window
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
            r_rcnt  <= 5'd0;
            r_x     <= 16'd0;
            r_y     <= 16'd0;
            r_w0    <= 16'd0;
            r_w1    <= 16'd0;
            r_w2    <= 16'd0;
            r_w3    <= 16'd0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (bus.in_valid) begin
                        r_x     <= bus.ciphertext[31:16];
                        r_y     <= bus.ciphertext[15:0];
                        r_w0    <= bus.key[15:0];
                        r_w1    <= bus.key[31:16];
                        r_w2    <= bus.key[47:32];
                        r_w3    <= bus.key[63:48];
                        r_rcnt  <= 5'd0;
                        r_state <= c_kexp;
                    end
                end
                c_kexp: begin
                    r_w0 <= r_w1;
                    r_w1 <= r_w2;
                    r_w2 <= r_w3;
                    r_w3 <= w_kfwd;
                    if (r_rcnt == c_kexp_last) begin
                        r_rcnt  <= 5'd0;
                        r_state <= c_dec;
                    end else begin
                        r_rcnt <= r_rcnt + 5'd1;
                    end
                end
                c_dec: begin
                    r_x  <= r_y;
                    r_y  <= w_y_new;
                    r_w3 <= r_w2;
                    r_w2 <= r_w1;
                    r_w1 <= r_w0;
                    // once k0 has entered the window the last rounds just drain it
                    r_w0 <= (r_rcnt <= c_kexp_last) ? w_kback : 16'd0;
                    if (r_rcnt == c_dec_last) begin
                        r_rcnt  <= 5'd0;
                        r_state <= c_done;
                    end else begin
                        r_rcnt <= r_rcnt + 5'd1;
                    end
                end
                c_done: begin
                    if (bus.out_ready) begin
                        r_state <= c_idle;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_simon_decrypt_iterative.sv
`default_nettype none
// ============================================================================
// Module      : tb_simon_decrypt_iterative
// Description : Self-checking bench for simon_decrypt_iterative: vector table,
//               handshake corner cases and a randomized sweep against an
//               independent forward SIMON32/64 encryptor model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simon_decrypt_iterative;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    simon_decrypt_iterative_if bus();

    simon_decrypt_iterative dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] key;
        logic [31:0] pt;
        logic [31:0] ct;
    } vec_t;

    vec_t tbl[6];

    localparam logic [63:0] c_kat_key = 64'h1918_1110_0908_0100;
    localparam logic [31:0] c_kat_ct  = 32'hC69B_E9BB;
    localparam logic [31:0] c_kat_pt  = 32'h6565_6877;

    function automatic logic [15:0] rol16(input logic [15:0] v, input int n);
        return (v << n) | (v >> (16 - n));
    endfunction

    function automatic logic [15:0] ror16(input logic [15:0] v, input int n);
        return (v >> n) | (v << (16 - n));
    endfunction

    // Reference forward encryptor with a fully stored key schedule
    function automatic logic [31:0] simon_enc(input logic [63:0] k, input logic [31:0] pt);
        logic [15:0] ks[32];
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] tmp;
        logic [61:0] z;
        z = 62'b11111010001001010110000111001101111101000100101011000011100110;
        for (int i = 0; i < 4; i++) ks[i] = k[16*i +: 16];
        for (int i = 4; i < 32; i++) begin
            tmp   = ror16(ks[i-1], 3) ^ ks[i-3];
            tmp   = tmp ^ ror16(tmp, 1);
            ks[i] = ~ks[i-4] ^ tmp ^ {15'd0, z[65-i]} ^ 16'd3;
        end
        x = pt[31:16];
        y = pt[15:0];
        for (int i = 0; i < 32; i++) begin
            tmp = x;
            x   = y ^ (rol16(x, 1) & rol16(x, 8)) ^ rol16(x, 2) ^ ks[i];
            y   = tmp;
        end
        return {x, y};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Offer one job; returns at the negedge just after the accepting edge
    task automatic start_job(input logic [63:0] k, input logic [31:0] ct);
        int n;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", 64'(bus.in_ready), 64'd1);
        bus.key        = k;
        bus.ciphertext = ct;
        bus.in_valid   = 1'b1;
        @(negedge clk);
        bus.in_valid   = 1'b0;
    endtask

    // Counts clock edges (after the accepting edge) until out_valid is seen
    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("out_valid_wait", 64'(bus.out_valid), 64'd1);
    endtask

    // Full job with out_ready high: latency, result and return to idle
    task automatic run_vec(input string name, input logic [63:0] k,
                           input logic [31:0] ct, input logic [31:0] pt);
        int lat;
        start_job(k, ct);
        chk({name, "_busy"}, 64'({bus.busy, bus.in_ready}), 64'b10);
        wait_out(lat);
        // out_valid first visible in cycle T+61, i.e. 60 edges after acceptance
        chk({name, "_latency"}, 64'(lat), 64'd60);
        chk({name, "_pt"}, 64'(bus.plaintext), 64'(pt));
        chk({name, "_excl"}, 64'({bus.in_ready, bus.busy}), 64'b00);
        @(negedge clk);
        chk({name, "_idle"}, 64'({bus.in_ready, bus.out_valid}), 64'b10);
    endtask

    initial begin
        int          lat;
        logic        ok_v;
        logic        ok_p;
        logic        ok_r;
        logic [31:0] held;
        logic [63:0] rk;
        logic [31:0] rp;

        total = 0;
        bad   = 0;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b1;
        bus.key        = 64'd0;
        bus.ciphertext = 32'd0;

        tbl[0] = '{key: c_kat_key, pt: c_kat_pt, ct: c_kat_ct};
        tbl[1] = '{key: 64'h0, pt: 32'h0, ct: 32'h0};
        tbl[2] = '{key: 64'hFFFF_FFFF_FFFF_FFFF, pt: 32'hFFFF_FFFF, ct: 32'h0};
        tbl[3] = '{key: 64'h0, pt: 32'hFFFF_FFFF, ct: 32'h0};
        tbl[4] = '{key: 64'hFFFF_FFFF_FFFF_FFFF, pt: 32'h0, ct: 32'h0};
        tbl[5] = '{key: 64'h0123_4567_89AB_CDEF, pt: 32'h8000_0001, ct: 32'h0};
        for (int i = 1; i < 6; i++) tbl[i].ct = simon_enc(tbl[i].key, tbl[i].pt);

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_flags", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b100);
        chk("reset_pt", 64'(bus.plaintext), 64'd0);
        chk("model_kat", 64'(simon_enc(c_kat_key, c_kat_pt)), 64'(c_kat_ct));

        // table of directed vectors
        for (int i = 0; i < 6; i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i].key, tbl[i].ct, tbl[i].pt);
        end

        // consumer stalls for 20 cycles
        bus.out_ready = 1'b0;
        start_job(c_kat_key, c_kat_ct);
        wait_out(lat);
        held = bus.plaintext;
        ok_v = 1'b1;
        ok_p = 1'b1;
        ok_r = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1) ok_v = 1'b0;
            if (bus.plaintext !== held) ok_p = 1'b0;
            if (bus.in_ready !== 1'b0)  ok_r = 1'b0;
        end
        chk("stall_valid", 64'(ok_v), 64'd1);
        chk("stall_pt", 64'(bus.plaintext), 64'(c_kat_pt));
        chk("stall_pt_stable", 64'(ok_p), 64'd1);
        chk("stall_in_ready_low", 64'(ok_r), 64'd1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("stall_release", 64'({bus.in_ready, bus.out_valid}), 64'b10);

        // reset in the middle of the inverse rounds
        start_job(c_kat_key, c_kat_ct);
        repeat (39) @(negedge clk);
        chk("midrst_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_flags", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b100);
        @(negedge clk);
        chk("midrst_still_idle", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b100);
        run_vec("after_rst", c_kat_key, c_kat_ct, c_kat_pt);

        // in_valid with other data while busy must be ignored
        start_job(c_kat_key, c_kat_ct);
        bus.key        = 64'hDEAD_BEEF_0BAD_F00D;
        bus.ciphertext = 32'h1234_5678;
        bus.in_valid   = 1'b1;
        repeat (30) @(negedge clk);
        bus.in_valid   = 1'b0;
        wait_out(lat);
        chk("ignore_latency", 64'(lat + 30), 64'd60);
        chk("ignore_pt", 64'(bus.plaintext), 64'(c_kat_pt));
        @(negedge clk);

        // back-to-back jobs with in_valid waiting during DONE
        start_job(c_kat_key, c_kat_ct);
        wait_out(lat);
        chk("b2b_first_pt", 64'(bus.plaintext), 64'(c_kat_pt));
        bus.key        = tbl[5].key;
        bus.ciphertext = tbl[5].ct;
        bus.in_valid   = 1'b1;
        @(negedge clk);
        chk("b2b_idle", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b100);
        @(negedge clk);
        chk("b2b_accept", 64'({bus.in_ready, bus.busy}), 64'b01);
        bus.in_valid = 1'b0;
        wait_out(lat);
        chk("b2b_latency", 64'(lat), 64'd60);
        chk("b2b_second_pt", 64'(bus.plaintext), 64'(tbl[5].pt));
        @(negedge clk);

        // randomized round trips through the reference encryptor
        for (int n = 0; n < 1000; n++) begin
            rk = {$urandom, $urandom};
            rp = $urandom;
            start_job(rk, simon_enc(rk, rp));
            wait_out(lat);
            chk($sformatf("rand%0d_pt", n), 64'(bus.plaintext), 64'(rp));
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
